seq_booth_mult: RTL and testbench
=================================

SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; SHALL be even and >= 4.
REQ-002 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand pair and mode present.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: a  input  WIDTH  multiplicand.
REQ-008 Port: b  input  WIDTH  multiplier.
REQ-009 Port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 Port: abort  input  1  synchronous cancel of the operation in flight.
REQ-011 Port: out_valid  output  1  product valid.
REQ-012 Port: out_ready  input  1  consumer accepts product.
REQ-013 Port: product  output  2*WIDTH  result.
REQ-014 Port: busy  output  1  high in CALC or DONE.
REQ-015 Port: op_count  output  CNT_W  number of products consumed.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-018 On an edge with in_valid && in_ready, the block SHALL capture a, b and is_signed, clear the accumulator and the digit counter, and enter CALC.
REQ-019 In CALC, each cycle SHALL retire one radix-4 Booth digit (recoded from three multiplier bits) by adding 0, +/-A or +/-2A to the accumulator; CALC SHALL last exactly WIDTH/2 cycles.
REQ-020 Operands SHALL be extended to WIDTH+2 bits internally: sign-extended when is_signed=1, zero-extended when is_signed=0.
REQ-021 For WIDTH=8, the first digit SHALL use bits {b[1],b[0],0}, and the top digit SHALL cover the extension bits, so unsigned 0xFF*0xFF is exact.
REQ-022 Latency: operands accepted at edge k SHALL produce out_valid=1 after edge k+WIDTH/2, with product stable and registered.
REQ-023 Arithmetic SHALL be exact modulo 2^(2*WIDTH), with no saturation and no overflow flag.
REQ-024 In DONE, out_valid SHALL be 1, and product and out_valid SHALL hold unchanged while out_ready=0.
REQ-025 On an edge in DONE with out_ready=1, the block SHALL enter IDLE and increment op_count.
REQ-026 op_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 abort=1 in CALC or DONE SHALL force IDLE on the next edge, with out_valid=0 and op_count unchanged; abort SHALL take priority over out_ready.
REQ-028 abort=1 in IDLE SHALL have no effect.
REQ-029 abort=1 and in_valid=1 together in IDLE SHALL result in the operands being accepted.
REQ-030 Changes to a, b or is_signed after acceptance SHALL NOT affect the result in flight.
REQ-031 out_valid SHALL be 0 in IDLE and CALC, and product SHALL retain its last value outside DONE.

Reset
REQ-032 reset_n=0 SHALL immediately, without a clock, force IDLE, product=0, out_valid=0, busy=0, op_count=0, digit counter=0 and in_ready=1.
REQ-033 Reset asserted mid-CALC or mid-DONE SHALL discard the operation, with no out_valid pulse after release.
REQ-034 Operation SHALL resume on the first rising edge after reset_n deasserts.

Verification (WIDTH=8)
REQ-035 Unsigned a=0xFF, b=0xFF, out_ready=1 -> product=0xFE01, out_valid rises 4 cycles after acceptance, op_count 0->1.
REQ-036 Signed a=0x80, b=0x80 -> 0x4000; signed a=0xFF, b=0x05 -> 0xFFFB; unsigned a=0xFF, b=0x05 -> 0x04FB.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> product and out_valid hold, in_ready=0, and new in_valid is ignored; out_ready=1 -> IDLE next edge.
REQ-038 abort in the 2nd CALC cycle -> IDLE next edge, no out_valid, op_count unchanged; the next op 0x03*0x07 returns 0x0015.
REQ-039 reset_n pulsed low mid-CALC -> outputs zero asynchronously, no out_valid after release; a subsequent op runs normally.
REQ-040 Random signed and unsigned back-to-back ops vs. a reference model; op_count preset near 0xFFFF -> wraps to 0x0000.

Source files
------------

// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier: one recoded digit per cycle, valid/ready
// handshakes on both sides, abort, and a count of consumed products.
module seq_booth_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int PW     = 2 * WIDTH;
  localparam int BW     = WIDTH + 3;
  localparam int DIGITS = WIDTH / 2;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   product_q;
  logic [BW-1:0]   mplier_q;
  logic [DW-1:0]   digit_q;
  logic [CNT_W-1:0] count_q;
  logic [PW-1:0]   acc_sum;
  logic            last_digit;

  function automatic logic [PW-1:0] booth_pp(input logic [2:0] bits, input logic [PW-1:0] m);
    case (bits)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m << 1;
      3'b100:         booth_pp = -(m << 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = {PW{1'b0}};
    endcase
  endfunction

  // The digit above the operand MSB only sees extension bits, so it is folded
  // into the last cycle to keep CALC at WIDTH/2 cycles.
  assign last_digit = (digit_q == LAST);

  always_comb begin
    acc_sum = acc_q + booth_pp(mplier_q[2:0], mcand_q);
    if (last_digit)
      acc_sum = acc_sum + booth_pp(mplier_q[4:2], mcand_q << 2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
        if (abort)           state_d = IDLE;
        else if (last_digit) state_d = DONE;
      end
      DONE: if (abort || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      digit_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{WIDTH{is_signed & a[WIDTH-1]}}, a};
            mplier_q <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
            acc_q    <= '0;
            digit_q  <= '0;
          end
        end
        CALC: begin
          if (!abort) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 2;
            mplier_q <= {{2{mplier_q[BW-1]}}, mplier_q[BW-1:2]};
            digit_q  <= digit_q + 1'b1;
            if (last_digit) product_q <= acc_sum;
          end
        end
        DONE: begin
          if (!abort && out_ready) count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed and random checks of seq_booth_mult (WIDTH=8), plus a narrow-counter
// instance that makes op_count wraparound observable in a short run.
module tb_seq_booth_mult;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [15:0] op_count;

  logic        in_ready_w;
  logic        out_valid_w;
  logic [15:0] product_w;
  logic        busy_w;
  logic [1:0]  op_count_w;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[15];

  seq_booth_mult #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy), .op_count(op_count)
  );

  seq_booth_mult #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .is_signed(is_signed), .abort(abort), .out_valid(out_valid_w),
    .out_ready(out_ready), .product(product_w), .busy(busy_w), .op_count(op_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one operand pair for a single edge, then scramble the inputs.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    a = av;
    b = bv;
    is_signed = sv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    is_signed = ~sv;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic [15:0] expected, input string name);
    int cycles;
    out_ready = 1'b1;
    applyStimulus(av, bv, sv);
    checkOutput({name, " busy"}, {31'b0, busy}, 32'd1);
    checkOutput({name, " in_ready"}, {31'b0, in_ready}, 32'd0);
    waitDone(cycles);
    checkOutput({name, " latency"}, cycles, 32'd4);
    checkOutput({name, " product"}, {16'b0, product}, {16'b0, expected});
    checkOutput({name, " product_w"}, {16'b0, product_w}, {16'b0, expected});
    tick();
    exp_count++;
    checkOutput({name, " idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    checkOutput({name, " op_count"}, {16'b0, op_count}, exp_count & 32'hFFFF);
    checkOutput({name, " op_count_w"}, {30'b0, op_count_w}, exp_count & 32'h3);
  endtask

  initial begin
    int cycles;
    int seen;
    int p;
    logic [7:0] av;
    logic [7:0] bv;
    logic       sv;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h05, 1'b1, 16'hFFFB};
    vecs[3]  = '{8'hFF, 8'h05, 1'b0, 16'h04FB};
    vecs[4]  = '{8'h03, 8'h07, 1'b0, 16'h0015};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[6]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[7]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    vecs[8]  = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
    vecs[9]  = '{8'h00, 8'hAB, 1'b1, 16'h0000};
    vecs[10] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[11] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[12] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
    vecs[13] = '{8'hAA, 8'h55, 1'b0, 16'h3872};
    vecs[14] = '{8'hAA, 8'h55, 1'b1, 16'hE372};

    reset_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset product", {16'b0, product}, 32'd0);
    checkOutput("reset op_count", {16'b0, op_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) runOp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].expected, $sformatf("vec%0d", i));

    // Backpressure: hold DONE for 10 cycles while offering new operands.
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0);
    waitDone(cycles);
    checkOutput("bp latency", cycles, 32'd4);
    for (int i = 0; i < 10; i++) begin
      a = 8'hEE;
      b = 8'hDD;
      in_valid = 1'b1;
      tick();
      checkOutput("bp hold", {14'b0, out_valid, in_ready, product}, {16'b0, 16'h0000} | 32'h2_03A8);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_count++;
    checkOutput("bp release", {30'b0, in_ready, out_valid}, 32'd2);
    checkOutput("bp op_count", {16'b0, op_count}, exp_count & 32'hFFFF);
    checkOutput("bp product kept", {16'b0, product}, 32'h03A8);

    // Abort in the second CALC cycle.
    applyStimulus(8'h55, 8'h55, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort calc idle", {29'b0, in_ready, out_valid, busy}, 32'd4);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("abort calc no valid", seen, 32'd0);
    checkOutput("abort calc op_count", {16'b0, op_count}, exp_count & 32'hFFFF);
    checkOutput("abort calc product kept", {16'b0, product}, 32'h03A8);
    runOp(8'h03, 8'h07, 1'b0, 16'h0015, "after abort");

    // Abort in DONE wins over out_ready.
    out_ready = 1'b0;
    applyStimulus(8'h10, 8'h10, 1'b0);
    waitDone(cycles);
    checkOutput("abort done product", {16'b0, product}, 32'h0100);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort done idle", {30'b0, in_ready, out_valid}, 32'd2);
    checkOutput("abort done op_count", {16'b0, op_count}, exp_count & 32'hFFFF);

    // Abort together with in_valid in IDLE still accepts.
    abort = 1'b1;
    runOp(8'h0B, 8'h0D, 1'b0, 16'h008F, "abort idle accept");

    // Reset pulse mid-CALC.
    applyStimulus(8'h77, 8'h66, 1'b0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    checkOutput("midreset outputs", {12'b0, in_ready, out_valid, busy, 1'b0, product}, 32'h8_0000);
    checkOutput("midreset op_count", {16'b0, op_count}, 32'd0);
    #2;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("midreset no valid", seen, 32'd0);
    runOp(8'h09, 8'h09, 1'b1, 16'h0051, "after reset");

    // Random back-to-back ops against an integer reference.
    for (int i = 0; i < 24; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      sv = 1'($urandom_range(0, 1));
      p = sv ? int'($signed(av)) * int'($signed(bv)) : int'(av) * int'(bv);
      runOp(av, bv, sv, p[15:0], $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
